// File: rtl/wts_i2s_tx_pkg.sv
// Shared constants, types and sample conversion for the wave table I2S transmitter.
package wts_i2s_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned IN_BITS    = 12;

  typedef logic [$clog2(FRAME_BITS)-1:0] bit_idx_t;
  typedef logic [DATA_BITS-1:0]          sample_t;
  typedef logic [IN_BITS-1:0]            raw_t;

  localparam bit_idx_t LATCH_BIT     = bit_idx_t'(63);
  localparam bit_idx_t RIGHT_START   = bit_idx_t'(32);
  localparam bit_idx_t LEFT_END      = bit_idx_t'(DATA_BITS);
  localparam bit_idx_t RIGHT_END     = RIGHT_START + LEFT_END;
  localparam bit_idx_t LRCK_HI_FIRST = RIGHT_START - bit_idx_t'(1);

  typedef enum logic [1:0] {
    REG_LEFT,
    REG_RIGHT,
    REG_PAD
  } region_e;

  function automatic region_e region_of(bit_idx_t n);
    if (n < LEFT_END)                         return REG_LEFT;
    else if (n >= RIGHT_START && n < RIGHT_END) return REG_RIGHT;
    else                                      return REG_PAD;
  endfunction

  // Offset binary to left-justified two's complement: flip the MSB, pad the LSBs.
  function automatic sample_t conv(raw_t s);
    return {~s[IN_BITS-1], s[IN_BITS-2:0], {(DATA_BITS-IN_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/wts_i2s_tx_if.sv
// Sample-side bus between the cartridge top and the I2S transmitter.
interface wts_i2s_tx_if
  import wts_i2s_pkg::*;
();

  raw_t left_in;
  raw_t right_in;
  logic mute;
  logic frame_req;

  modport master (output left_in, output right_in, output mute, input frame_req);
  modport slave  (input left_in, input right_in, input mute, output frame_req);

endinterface

// File: rtl/wts_i2s_tx_clkgen.sv
// BCLK divider and frame bit counter; fall/rise strobe the clk edge on which bclk toggles.
module wts_i2s_clkgen
  import wts_i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic     clk,
  input  logic     slot_nreset,
  output logic     bclk_o,
  output logic     fall_o,
  output bit_idx_t bit_nxt_o
);

  localparam int unsigned DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] TC = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  bit_idx_t      bit_cnt_q, bit_cnt_d;
  logic          tc, rise, fall;

  always_comb begin
    tc        = (div_cnt_q == TC);
    rise      = tc && !bclk_q;
    fall      = tc && bclk_q;
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (rise) bclk_d = 1'b1;
    if (fall) begin
      bclk_d    = 1'b0;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= LATCH_BIT;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bclk_o    = bclk_q;
  assign fall_o    = fall;
  assign bit_nxt_o = bit_cnt_q + 1'b1;

endmodule

// File: rtl/wts_i2s_tx.sv
// I2S transmitter: latches both channels once per frame and shifts them out MSB first.
module wts_i2s_tx
  import wts_i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic         clk,
  input  logic         slot_nreset,
  wts_i2s_tx_if.slave  src,
  output logic         i2s_bclk,
  output logic         i2s_lrck,
  output logic         i2s_sdata
);

  logic     fall;
  bit_idx_t bit_nxt;
  logic     enter_latch;

  sample_t hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  sample_t sr_l_q, sr_l_d, sr_r_q, sr_r_d;
  logic    lrck_q, lrck_d, sdata_q, sdata_d, frame_req_q, frame_req_d;

  wts_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk         (clk),
    .slot_nreset (slot_nreset),
    .bclk_o      (i2s_bclk),
    .fall_o      (fall),
    .bit_nxt_o   (bit_nxt)
  );

  assign enter_latch = fall && (bit_nxt == LATCH_BIT);

  // Everything below is keyed on the bit index being entered at this bclk fall.
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    sr_l_d      = sr_l_q;
    sr_r_d      = sr_r_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    frame_req_d = enter_latch;
    if (enter_latch) begin
      hold_l_d = src.mute ? '0 : conv(src.left_in);
      hold_r_d = src.mute ? '0 : conv(src.right_in);
    end
    if (fall) begin
      lrck_d  = (bit_nxt >= LRCK_HI_FIRST) && (bit_nxt < LATCH_BIT);
      sdata_d = 1'b0;
      unique case (region_of(bit_nxt))
        REG_LEFT: begin
          if (bit_nxt == '0) begin
            sr_l_d  = hold_l_q;
            sdata_d = hold_l_q[DATA_BITS-1];
          end else begin
            sdata_d = sr_l_q[DATA_BITS-2];
            sr_l_d  = {sr_l_q[DATA_BITS-2:0], 1'b0};
          end
        end
        REG_RIGHT: begin
          if (bit_nxt == RIGHT_START) begin
            sr_r_d  = hold_r_q;
            sdata_d = hold_r_q[DATA_BITS-1];
          end else begin
            sdata_d = sr_r_q[DATA_BITS-2];
            sr_r_d  = {sr_r_q[DATA_BITS-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sr_l_q      <= '0;
      sr_r_q      <= '0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      frame_req_q <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sr_l_q      <= sr_l_d;
      sr_r_q      <= sr_r_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      frame_req_q <= frame_req_d;
    end
  end

  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;
  assign src.frame_req = frame_req_q;

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Bench for wts_i2s_tx at BCLK_DIV 4 and 2 against a clk-count based behavioural model.
module tb_wts_i2s_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [11:0] left = 12'h123;
  logic [11:0] right = 12'h123;
  logic        mute = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wts_i2s_tx_if if0 ();
  wts_i2s_tx_if if1 ();
  assign if0.left_in  = left;
  assign if0.right_in = right;
  assign if0.mute     = mute;
  assign if1.left_in  = left;
  assign if1.right_in = right;
  assign if1.mute     = mute;

  logic bclk0, lrck0, sdata0, bclk1, lrck1, sdata1;

  wts_i2s_tx #(.BCLK_DIV(4)) dut0 (
    .clk(clk), .slot_nreset(nreset), .src(if0.slave),
    .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_sdata(sdata0)
  );
  wts_i2s_tx #(.BCLK_DIV(2)) dut1 (
    .clk(clk), .slot_nreset(nreset), .src(if1.slave),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1)
  );

  // {frame_req, bclk, lrck, sdata}
  logic [3:0] obs [2];
  assign obs[0] = {if0.frame_req, bclk0, lrck0, sdata0};
  assign obs[1] = {if1.frame_req, bclk1, lrck1, sdata1};

  function automatic int unsigned dv(int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [15:0] mconv(logic [11:0] s);
    int v;
    v = (int'(s) - 2048) * 16;
    return v[15:0];
  endfunction

  // Model state: clk edges since release, pending latched words, words of the frame in flight.
  int unsigned t [2] = '{0, 0};
  logic [15:0] pl [2] = '{16'h0, 16'h0};
  logic [15:0] pr [2] = '{16'h0, 16'h0};
  logic [15:0] cl [2] = '{16'h0, 16'h0};
  logic [15:0] cr [2] = '{16'h0, 16'h0};

  always @(posedge clk or negedge nreset) begin
    for (int k = 0; k < 2; k++) begin
      if (!nreset) begin
        t[k]  <= 0;
        pl[k] <= 16'h0;
        pr[k] <= 16'h0;
        cl[k] <= 16'h0;
        cr[k] <= 16'h0;
      end else begin
        t[k] <= t[k] + 1;
        if ((t[k] + 1) % (128 * dv(k)) == 0) begin
          pl[k] <= mute ? 16'h0 : mconv(left);
          pr[k] <= mute ? 16'h0 : mconv(right);
        end
        if ((t[k] + 1) % (128 * dv(k)) == 2 * dv(k)) begin
          cl[k] <= pl[k];
          cr[k] <= pr[k];
        end
      end
    end
  end

  function automatic logic [3:0] expect_out(int unsigned tt, int unsigned d,
                                            logic [15:0] l, logic [15:0] r);
    int unsigned n;
    logic b, lr, sd, fr;
    n  = (63 + tt / (2 * d)) % 64;
    b  = ((tt / d) % 2) == 1;
    lr = (n >= 31) && (n <= 62);
    if (n < 16)                 sd = l[15 - n];
    else if (n >= 32 && n < 48) sd = r[47 - n];
    else                        sd = 1'b0;
    fr = (tt != 0) && (tt % (128 * d) == 0);
    return {fr, b, lr, sd};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] e;
      e = expect_out(t[k], dv(k), cl[k], cr[k]);
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL pins_div%0d t=%0d got %b want %b ({frame_req,bclk,lrck,sdata})",
                 dv(k), t[k], obs[k], e);
      end
    end
  end

  // Independent deserializer on dut0 driven only by its pins: lrck edge marks the delay bit.
  int          pos = -1;
  int          npos;
  logic        prev_lr = 1'b0;
  logic [15:0] acc = 16'h0;
  logic [15:0] last_l = 16'hFFFF;
  logic [15:0] last_r = 16'hFFFF;
  int          pad_cnt = 0;

  assign npos = (lrck0 !== prev_lr) ? 0 : pos + 1;

  always @(posedge bclk0 or negedge nreset) begin
    if (!nreset) begin
      pos     <= -1;
      prev_lr <= 1'b0;
      acc     <= 16'h0;
    end else begin
      pos     <= npos;
      prev_lr <= lrck0;
      if (npos >= 1 && npos <= 16) acc <= {acc[14:0], sdata0};
      if (npos == 16) begin
        if (lrck0) last_r <= {acc[14:0], sdata0};
        else       last_l <= {acc[14:0], sdata0};
      end
      if ((npos == 0 || npos > 16) && sdata0) pad_cnt <= pad_cnt + 1;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_fr(int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obs[k][3] !== 1'b1 && n < 5000);
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL frame_req_timeout_div%0d waited %0d want <5000", dv(k), n);
    end
  endtask

  task automatic bclk_period(int k, output int n);
    logic p;
    int guard;
    guard = 0;
    p = obs[k][2];
    do begin @(negedge clk); guard++; end while (!(p === 1'b0 && obs[k][2] === 1'b1 && (p = 1'b1))
                                                  && ((p = obs[k][2]) || 1'b1) && guard < 100);
    n = 0;
    p = obs[k][2];
    do begin
      @(negedge clk);
      n++;
      if (p === 1'b0 && obs[k][2] === 1'b1) break;
      p = obs[k][2];
    end while (n < 100);
  endtask

  int n, pad0;

  initial begin
    check("conv_000", mconv(12'h000), 16'h8000);
    check("conv_fff", mconv(12'hFFF), 16'h7FF0);
    check("conv_800", mconv(12'h800), 16'h0000);
    check("conv_abc", mconv(12'hABC), 16'h2BC0);

    repeat (3) @(negedge clk);
    check("reset_pins_div4", obs[0], 4'b0000);
    check("reset_pins_div2", obs[1], 4'b0000);
    @(negedge clk) nreset = 1'b1;
    pad0 = pad_cnt;
    wait_fr(0, n);
    check("first_frame_req_clk", n, 512);
    check("frame0_left_silent", last_l, 16'h0000);
    check("frame0_right_silent", last_r, 16'h0000);
    check("frame0_pad", pad_cnt - pad0, 0);

    left = 12'hFFF;
    right = 12'h000;
    wait_fr(0, n);
    check("frame_period_div4", n, 512);
    pad0 = pad_cnt;
    wait_fr(0, n);
    check("ext_left", last_l, 16'h7FF0);
    check("ext_right", last_r, 16'h8000);
    check("ext_pad_zero", pad_cnt - pad0, 0);
    bclk_period(0, n);
    check("bclk_period_div4", n, 8);
    bclk_period(1, n);
    check("bclk_period_div2", n, 4);
    wait_fr(1, n);
    wait_fr(1, n);
    check("frame_period_div2", n, 256);

    left = 12'h800;
    wait_fr(0, n);
    repeat (8 + 5 * 8) @(negedge clk);
    left = 12'hABC;
    wait_fr(0, n);
    check("inflight_left_unchanged", last_l, 16'h0000);
    wait_fr(0, n);
    check("next_left_abc", last_l, 16'h2BC0);

    left = 12'hFFF;
    right = 12'hFFF;
    mute = 1'b1;
    wait_fr(0, n);
    repeat (100) @(negedge clk);
    mute = 1'b0;
    wait_fr(0, n);
    check("mute_left", last_l, 16'h0000);
    check("mute_right", last_r, 16'h0000);
    wait_fr(0, n);
    check("unmute_left", last_l, 16'h7FF0);
    check("unmute_right", last_r, 16'h7FF0);

    for (int i = 0; i < 160; i++) begin
      repeat ($urandom_range(5, 70)) @(negedge clk);
      left  = 12'($urandom);
      right = 12'($urandom);
      if ($urandom_range(0, 7) == 0) left = 12'h000;
      if ($urandom_range(0, 7) == 0) right = 12'hFFF;
      mute  = ($urandom_range(0, 4) == 0);
    end

    mute = 1'b0;
    left = 12'hFFF;
    right = 12'hFFF;
    wait_fr(0, n);
    wait_fr(0, n);
    repeat (8 + 40 * 8) @(negedge clk);
    check("prereset_left", last_l, 16'h7FF0);
    #2 nreset = 1'b0;
    #1;
    check("midframe_reset_div4", obs[0], 4'b0000);
    check("midframe_reset_div2", obs[1], 4'b0000);
    repeat (5) @(negedge clk);
    nreset = 1'b1;
    wait_fr(0, n);
    check("rerelease_first_fr", n, 512);
    check("rerelease_left_silent", last_l, 16'h0000);
    check("rerelease_right_silent", last_r, 16'h0000);
    wait_fr(0, n);
    wait_fr(0, n);
    check("rerelease_data", last_r, 16'h7FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time %0t limit 2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
